// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared definitions for the N-to-2^N sequential decoder: FSM states, mode
// encodings and the one-hot helper.
package decoder_nto2n_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Widest one-hot vector the helper can build; callers cast down to 2^N.
  localparam int ONEHOT_MAX_W = 64;

  function automatic logic [ONEHOT_MAX_W-1:0] onehot(input int i);
    return ONEHOT_MAX_W'(1) << i;
  endfunction

endpackage

// File: rtl/decoder_dwell_cnt.sv
// Dwell counter: counts 0..DWELL-1 while enabled; tick flags the terminal count.
module decoder_dwell_cnt #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] TC = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TC);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with a DECODE (latch and hold) mode and a
// SCAN mode that walks one active bit through all outputs with a fixed dwell.
//
//   state   | meaning
//   --------+------------------------------------------------
//   ST_IDLE | nothing loaded yet, out = 0
//   ST_HOLD | static one-hot value held until next load/scan
//   ST_SCAN | rotating bit, advances on each dwell tick
module decoder_nto2n_seq
  import decoder_nto2n_seq_pkg::*;
#(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              in_valid,
  input  logic [N-1:0]      in,
  output logic [(1<<N)-1:0] out,
  output logic              out_valid,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int W = 1 << N;

  state_t         state_q, state_d;
  logic [N-1:0]   idx_q, idx_d;
  logic [W-1:0]   out_q, out_d;
  logic           valid_q, valid_d;
  logic           wrap_q, wrap_d;
  logic           cnt_en, cnt_clr, tick;

  decoder_dwell_cnt #(.DWELL(DWELL)) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .clr  (cnt_clr),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    out_d   = out_q;
    wrap_d  = 1'b0;
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    if (en) begin
      case (mode)
        MODE_SCAN: begin
          if (state_q != ST_SCAN) begin
            state_d = ST_SCAN;
            idx_d   = '0;
            valid_d = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (tick) begin
              idx_d  = idx_q + N'(1);
              wrap_d = (idx_q == '1);
            end
          end
        end
        MODE_DECODE: begin
          // Leaving SCAN only freezes the current index; loads wait a cycle.
          if (state_q == ST_SCAN) begin
            state_d = ST_HOLD;
          end else if (in_valid) begin
            state_d = ST_HOLD;
            idx_d   = in;
            valid_d = 1'b1;
          end
        end
      endcase
      out_d = valid_d ? W'(onehot(int'(idx_d))) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign idx       = idx_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Bench for decoder_nto2n_seq: directed vector table (N=2, DWELL=3), a DWELL=1
// scan sequence (N=3), and random stimulus against a scan-time reference model.
module tb_decoder_nto2n_seq;

  localparam int NA = 2, DA = 3, WA = 4;
  localparam int NB = 3, DB = 1, WB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, en, mode, in_valid;
  logic [NA-1:0] in_a;
  logic [NB-1:0] in_b;
  logic [WA-1:0] out_a;
  logic [WB-1:0] out_b;
  logic          ov_a, ov_b, wrap_a, wrap_b;
  logic [NA-1:0] idx_a;
  logic [NB-1:0] idx_b;

  decoder_nto2n_seq #(.N(NA), .DWELL(DA)) dut_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in(in_a),
    .out(out_a), .out_valid(ov_a), .idx(idx_a), .wrap(wrap_a));

  decoder_nto2n_seq #(.N(NB), .DWELL(DB)) dut_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid), .in(in_b),
    .out(out_b), .out_valid(ov_b), .idx(idx_b), .wrap(wrap_b));

  // Reference: in SCAN the index is just (enabled cycles since entry / DWELL) mod 2^N.
  typedef struct {
    bit          scan;
    bit          valid;
    int unsigned idx;
    int unsigned t;
    bit          wrap;
  } mstate_t;

  mstate_t ma, mb;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic mstate_t mstep(mstate_t s, int n, int dw, bit r, bit e, bit m,
                                    bit iv, int unsigned sel);
    mstate_t x = s;
    int unsigned w = 1 << n;
    x.wrap = 1'b0;
    if (r) begin
      x = '{default: 0};
    end else if (e) begin
      if (m) begin
        if (!s.scan) begin
          x.scan = 1'b1; x.t = 0; x.idx = 0; x.valid = 1'b1;
        end else begin
          x.t    = s.t + 1;
          x.idx  = (x.t / dw) % w;
          x.wrap = (x.t % (dw * w)) == 0;
        end
      end else if (s.scan) begin
        x.scan = 1'b0;
      end else if (iv) begin
        x.idx = sel; x.valid = 1'b1;
      end
    end
    return x;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    ma = mstep(ma, NA, DA, rst, en, mode, in_valid, in_a);
    mb = mstep(mb, NB, DB, rst, en, mode, in_valid, in_b);
    #1;
    chk("inv_a", ($countones(out_a) == ov_a) && (out_a == (ov_a ? WA'(1) << idx_a : '0)), 1);
    chk("inv_b", ($countones(out_b) == ov_b) && (out_b == (ov_b ? WB'(1) << idx_b : '0)), 1);
  endtask

  task automatic cmp_model();
    chk("mdl_a_out",  out_a,  ma.valid ? (64'd1 << ma.idx) : 64'd0);
    chk("mdl_a_vld",  ov_a,   ma.valid);
    chk("mdl_a_idx",  idx_a,  ma.idx);
    chk("mdl_a_wrap", wrap_a, ma.wrap);
    chk("mdl_b_out",  out_b,  mb.valid ? (64'd1 << mb.idx) : 64'd0);
    chk("mdl_b_idx",  idx_b,  mb.idx);
    chk("mdl_b_wrap", wrap_b, mb.wrap);
  endtask

  typedef struct {
    bit          rst, en, mode, iv;
    int unsigned sel;
    logic [3:0]  out;
    bit          v;
    int unsigned idx;
    bit          wrap;
  } vec_t;

  vec_t tab[$];

  task automatic add(int rep, bit r, bit e, bit m, bit iv, int unsigned sel,
                     logic [3:0] o, bit v, int unsigned ix, bit w);
    vec_t x;
    x.rst = r; x.en = e; x.mode = m; x.iv = iv; x.sel = sel;
    x.out = o; x.v = v; x.idx = ix; x.wrap = w;
    for (int k = 0; k < rep; k++) tab.push_back(x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    ma = '{default: 0};
    mb = '{default: 0};

    // reset, decode sweep, hold
    add(2, 1,1,0,0,0, 4'b0000,0,0,0);
    add(1, 0,1,0,1,0, 4'b0001,1,0,0);
    add(1, 0,1,0,1,1, 4'b0010,1,1,0);
    add(1, 0,1,0,1,2, 4'b0100,1,2,0);
    add(1, 0,1,0,1,3, 4'b1000,1,3,0);
    add(2, 0,1,0,0,1, 4'b1000,1,3,0);
    // full scan period with one wrap, in_valid ignored in SCAN
    add(3, 0,1,1,0,0, 4'b0001,1,0,0);
    add(3, 0,1,1,0,0, 4'b0010,1,1,0);
    add(3, 0,1,1,0,0, 4'b0100,1,2,0);
    add(3, 0,1,1,0,0, 4'b1000,1,3,0);
    add(1, 0,1,1,0,0, 4'b0001,1,0,1);
    add(2, 0,1,1,1,3, 4'b0001,1,0,0);
    add(1, 0,1,1,1,3, 4'b0010,1,1,0);
    // mode exit ignores same-edge load, next load takes effect
    add(1, 0,1,0,1,3, 4'b0010,1,1,0);
    add(1, 0,1,0,1,3, 4'b1000,1,3,0);
    add(1, 0,1,0,0,0, 4'b1000,1,3,0);
    // freeze mid-dwell at 0100, resume keeps count
    add(3, 0,1,1,0,0, 4'b0001,1,0,0);
    add(3, 0,1,1,0,0, 4'b0010,1,1,0);
    add(1, 0,1,1,0,0, 4'b0100,1,2,0);
    add(5, 0,0,1,0,0, 4'b0100,1,2,0);
    add(2, 0,1,1,0,0, 4'b0100,1,2,0);
    add(3, 0,1,1,0,0, 4'b1000,1,3,0);
    add(1, 0,1,1,0,0, 4'b0001,1,0,1);
    add(1, 0,0,1,0,0, 4'b0001,1,0,0);
    add(1, 0,1,1,0,0, 4'b0001,1,0,0);
    // reset mid-SCAN and mid-HOLD, frozen IDLE
    add(1, 1,1,1,0,0, 4'b0000,0,0,0);
    add(2, 0,1,1,0,0, 4'b0001,1,0,0);
    add(1, 0,1,0,1,2, 4'b0001,1,0,0);
    add(1, 0,1,0,1,2, 4'b0100,1,2,0);
    add(1, 1,1,0,1,1, 4'b0000,0,0,0);
    add(1, 0,0,0,1,1, 4'b0000,0,0,0);
    add(1, 0,0,1,0,0, 4'b0000,0,0,0);
    add(1, 0,1,0,0,1, 4'b0000,0,0,0);

    foreach (tab[i]) begin
      rst = tab[i].rst; en = tab[i].en; mode = tab[i].mode;
      in_valid = tab[i].iv; in_a = NA'(tab[i].sel); in_b = '0;
      tick_cycle();
      chk($sformatf("vec%0d_out", i),  out_a,  tab[i].out);
      chk($sformatf("vec%0d_vld", i),  ov_a,   tab[i].v);
      chk($sformatf("vec%0d_idx", i),  idx_a,  tab[i].idx);
      chk($sformatf("vec%0d_wrap", i), wrap_a, tab[i].wrap);
    end

    // DWELL=1, N=3: index advances every cycle, wrap every 8
    rst = 1'b1; en = 1'b1; mode = 1'b0; in_valid = 1'b0;
    tick_cycle();
    rst = 1'b0; mode = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick_cycle();
      chk($sformatf("d1_idx%0d", k),  idx_b,  k % 8);
      chk($sformatf("d1_wrap%0d", k), wrap_b, (k > 0) && (k % 8 == 0));
    end

    // random stimulus against the reference model
    for (int c = 0; c < 800; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      en       = ($urandom_range(0, 6) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      in_valid = $urandom_range(0, 1) == 1;
      in_a     = NA'($urandom);
      in_b     = NB'($urandom);
      tick_cycle();
      cmp_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
